// File: rtl/bist_tpg.sv
// ============================================================================
// Module  : bist_tpg
// Brief   : LFSR test-pattern generator with response-analyzer control for BIST
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bist_tpg #(
    parameter int NUM_PAT = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] seed,
    output logic [2:0] pat,
    output logic       ora_init,
    output logic       ora_en,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] LAST_CNT  = 3'(NUM_PAT - 1);
    localparam logic [2:0] LFSR_RST  = 3'b001;

    // Assertion is asynchronous; release is retimed through two flops.
    logic [1:0] rst_sync_q;
    logic       rst_sync_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_sync_q[1];

    state_t     state_q, state_d;
    logic [2:0] lfsr_q, lfsr_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] pat_q, pat_d;
    logic       ora_init_q, ora_init_d;
    logic       ora_en_q, ora_en_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q    <= IDLE;
            lfsr_q     <= LFSR_RST;
            cnt_q      <= 3'd0;
            pat_q      <= 3'd0;
            ora_init_q <= 1'b0;
            ora_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            cnt_q      <= cnt_d;
            pat_q      <= pat_d;
            ora_init_q <= ora_init_d;
            ora_en_q   <= ora_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        cnt_d      = cnt_q;
        pat_d      = 3'd0;
        ora_init_d = 1'b0;
        ora_en_d   = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = INIT;
                    lfsr_d  = (seed == 3'b000) ? LFSR_RST : seed;
                end
            end
            INIT: begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end
            RUN: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the upcoming state so they register with it.
        // lfsr_q always holds the pattern due in the next RUN cycle.
        case (state_d)
            INIT: begin
                ora_init_d = 1'b1;
                busy_d     = 1'b1;
            end
            RUN: begin
                ora_en_d = 1'b1;
                busy_d   = 1'b1;
                pat_d    = lfsr_q;
                lfsr_d   = {lfsr_q[1:0], lfsr_q[2] ^ lfsr_q[1]};
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                pat_d = 3'd0;
            end
        endcase
    end

    assign pat      = pat_q;
    assign ora_init = ora_init_q;
    assign ora_en   = ora_en_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_bist_tpg.sv
// ============================================================================
// Module  : tb_bist_tpg
// Brief   : Randomized self-checking bench for bist_tpg (NUM_PAT=7 and 3)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bist_tpg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start7, start3;
    logic [2:0] seed7, seed3;
    logic [2:0] pat7, pat3;
    logic       init7, init3, en7, en3, busy7, busy3, done7, done3;

    int n_tests = 0;
    int n_fail  = 0;
    bit cur_sel = 1'b0;

    logic [2:0] o_pat;
    logic       o_init, o_en, o_busy, o_done;

    always #5 clk = ~clk;

    bist_tpg #(.NUM_PAT(7)) u_dut7 (
        .clk(clk), .rst_n(rst_n), .start(start7), .seed(seed7), .pat(pat7),
        .ora_init(init7), .ora_en(en7), .busy(busy7), .done(done7)
    );

    bist_tpg #(.NUM_PAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .seed(seed3), .pat(pat3),
        .ora_init(init3), .ora_en(en3), .busy(busy3), .done(done3)
    );

    always_comb begin
        o_pat  = cur_sel ? pat3  : pat7;
        o_init = cur_sel ? init3 : init7;
        o_en   = cur_sel ? en3   : en7;
        o_busy = cur_sel ? busy3 : busy7;
        o_done = cur_sel ? done3 : done7;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: x^3+x^2+1 shift rule written as plain integer arithmetic
    function automatic int lfsr_next(input int s);
        return ((s * 2) % 8) + (((s / 4) ^ (s / 2)) & 1);
    endfunction

    task automatic set_start(input bit sel, input bit v);
        if (sel) start3 = v; else start7 = v;
    endtask

    task automatic set_seed(input bit sel, input int v);
        if (sel) seed3 = 3'(v); else seed7 = 3'(v);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_pat"},  o_pat,  0);
        check({tag, "_init"}, o_init, 0);
        check({tag, "_en"},   o_en,   0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
    endtask

    // Entered at a negedge with the DUT in IDLE; returns at the following IDLE negedge.
    task automatic run(input bit sel, input int sd, input bit noise, input bit keep);
        int n;
        int s;
        int mask;
        cur_sel = sel;
        n    = sel ? 3 : 7;
        s    = (sd == 0) ? 1 : sd;
        mask = 0;
        set_seed(sel, sd);
        set_start(sel, 1'b1);
        @(negedge clk);
        check("init_pulse", o_init, 1);
        check("init_busy",  o_busy, 1);
        check("init_pat",   o_pat,  0);
        check("init_en",    o_en,   0);
        check("init_done",  o_done, 0);
        if (!keep) set_start(sel, 1'b0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("run_pat",  o_pat,  s);
            check("run_en",   o_en,   1);
            check("run_busy", o_busy, 1);
            check("run_init", o_init, 0);
            check("run_done", o_done, 0);
            mask = mask | (1 << o_pat);
            s = lfsr_next(s);
            if (noise) begin
                set_start(sel, 1'($urandom_range(0, 1)));
                set_seed(sel, int'($urandom_range(0, 7)));
            end
        end
        @(negedge clk);
        check("done_pulse", o_done, 1);
        check("done_busy",  o_busy, 0);
        check("done_pat",   o_pat,  0);
        check("done_en",    o_en,   0);
        set_start(sel, keep);
        @(negedge clk);
        check_idle("post_idle");
        if (n == 7) check("all_states", mask, 'hFE);
    endtask

    task automatic reset_mid_run(input int sd, input int sd2);
        int s;
        cur_sel = 1'b0;
        s = (sd == 0) ? 1 : sd;
        seed7  = 3'(sd);
        start7 = 1'b1;
        @(negedge clk);
        check("rm_init", o_init, 1);
        start7 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rm_pat", o_pat, s);
            s = lfsr_next(s);
        end
        rst_n = 1'b0;
        #1;
        check_idle("rm_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("rm_held");
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_idle("rm_wait");
        end
        run(1'b0, sd2, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n  = 1'b0;
        start7 = 1'b0;
        start3 = 1'b0;
        seed7  = 3'd0;
        seed3  = 3'd0;
        #1;
        cur_sel = 1'b0;
        check_idle("reset7");
        cur_sel = 1'b1;
        #1;
        check_idle("reset3");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        run(1'b0, 1, 1'b0, 1'b0);
        run(1'b0, 0, 1'b0, 1'b0);
        run(1'b1, 7, 1'b0, 1'b0);
        run(1'b0, 5, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            run(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'b1, 1'b0);
        end
        reset_mid_run(int'($urandom_range(1, 7)), int'($urandom_range(0, 7)));
        run(1'b0, 3, 1'b0, 1'b1);
        run(1'b0, 3, 1'b0, 1'b1);
        start7 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_idle("final_idle");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
